// File: rtl/ucc_pkg.sv
// Shared types and constants for the up/down counter controller.
//   state_e          : burst engine state (idle, waiting on the step timer, done pulse)
//   DIR_UP, DIR_DOWN : encoding of burst_dir
package ucc_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/step_timer.sv
// Down-counter that paces the burst engine between steps.
//   sys_clk, reset : clock and synchronous active-high reset
//   load           : load value (takes priority over everything else)
//   value          : reload value (the burst period)
//   hold           : freeze the count
//   zero           : count is zero, i.e. a step is due
// The count never goes below zero, so a step that cannot be granted stays due.
module step_timer #(
    parameter int unsigned PER_W = 16
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             load,
    input  logic [PER_W-1:0] value,
    input  logic             hold,
    output logic             zero
);

    logic [PER_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (!hold && (cnt_q != '0)) begin
            cnt_d = cnt_q - PER_W'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/updown_count_ctrl.sv
// Host-triggered up/down counter with a scheduled burst engine.
//   sys_clk, reset         : clock and synchronous active-high reset
//   trig_reset/up/down     : host pulses; clear, +1, -1 (up and down together cancel)
//   burst_start/abort      : start a burst from idle / cancel a running burst
//   burst_len/period/dir   : burst config, latched at start
//   clear_flags            : clear sticky ovf/unf (a same-cycle set wins)
//   count, steps_left      : counter value and remaining burst steps
//   busy                   : burst waiting for or issuing steps
//   done                   : one-cycle pulse after the last burst step
//   ovf, unf               : sticky overflow/underflow flags
// Host triggers own the counter in their cycle; a due burst step is then retried.
module updown_count_ctrl
    import ucc_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LEN_W = 16,
    parameter int unsigned PER_W = 16,
    parameter bit          WRAP  = 1'b1
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             trig_reset,
    input  logic             trig_up,
    input  logic             trig_down,
    input  logic             burst_start,
    input  logic             burst_abort,
    input  logic [LEN_W-1:0] burst_len,
    input  logic [PER_W-1:0] burst_period,
    input  logic             burst_dir,
    input  logic             clear_flags,
    output logic [WIDTH-1:0] count,
    output logic [LEN_W-1:0] steps_left,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             unf
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [LEN_W-1:0] steps_left_q, steps_left_d;
    logic [PER_W-1:0] period_q, period_d;
    logic             dir_q, dir_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             timer_load;
    logic [PER_W-1:0] timer_value;
    logic             timer_zero;

    logic             host_trig;
    logic             step_grant;
    logic             do_step;
    logic             use_dec;
    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   sum;
    logic             ovf_evt;
    logic             unf_evt;

    step_timer #(
        .PER_W (PER_W)
    ) u_step_timer (
        .sys_clk (sys_clk),
        .reset   (reset),
        .load    (timer_load),
        .value   (timer_value),
        .hold    (state_q != StWait),
        .zero    (timer_zero)
    );

    assign host_trig  = trig_reset | trig_up | trig_down;
    // Abort also withholds the step so count is left exactly as it was.
    assign step_grant = (state_q == StWait) && timer_zero && !host_trig && !burst_abort;

    // Single +/-1 adder: decrement adds all-ones, so carry-out clear means we
    // went below zero; for increment, carry-out set means we passed all-ones.
    always_comb begin
        do_step = 1'b0;
        use_dec = 1'b0;
        if (!trig_reset) begin
            if (trig_up ^ trig_down) begin
                do_step = 1'b1;
                use_dec = trig_down;
            end else if (step_grant) begin
                do_step = 1'b1;
                use_dec = (dir_q == DIR_DOWN);
            end
        end
    end

    assign addend  = use_dec ? {1'b0, {WIDTH{1'b1}}} : (WIDTH + 1)'(1);
    assign sum     = {1'b0, count_q} + addend;
    assign ovf_evt = do_step && !use_dec && sum[WIDTH];
    assign unf_evt = do_step && use_dec && !sum[WIDTH];

    always_comb begin
        count_d = count_q;
        if (trig_reset) begin
            count_d = '0;
        end else if (do_step) begin
            if (!WRAP && (ovf_evt || unf_evt)) begin
                count_d = count_q;
            end else begin
                count_d = sum[WIDTH-1:0];
            end
        end
        ovf_d = ovf_evt || (ovf_q && !clear_flags);
        unf_d = unf_evt || (unf_q && !clear_flags);
    end

    always_comb begin
        state_d      = state_q;
        steps_left_d = steps_left_q;
        period_d     = period_q;
        dir_d        = dir_q;
        timer_load   = 1'b0;
        timer_value  = period_q;
        unique case (state_q)
            StIdle: begin
                if (burst_start) begin
                    if (burst_len != '0) begin
                        state_d      = StWait;
                        steps_left_d = burst_len;
                        period_d     = burst_period;
                        dir_d        = burst_dir;
                        timer_load   = 1'b1;
                        timer_value  = burst_period;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StWait: begin
                if (burst_abort) begin
                    state_d = StIdle;
                end else if (step_grant) begin
                    steps_left_d = steps_left_q - LEN_W'(1);
                    if (steps_left_q == LEN_W'(1)) begin
                        state_d = StDone;
                    end else begin
                        timer_load = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q      <= StIdle;
            count_q      <= '0;
            steps_left_q <= '0;
            period_q     <= '0;
            dir_q        <= DIR_UP;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            steps_left_q <= steps_left_d;
            period_q     <= period_d;
            dir_q        <= dir_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
        end
    end

    assign count      = count_q;
    assign steps_left = steps_left_q;
    assign busy       = (state_q == StWait);
    // An abort in the done cycle swallows the pulse.
    assign done       = (state_q == StDone) && !burst_abort;
    assign ovf        = ovf_q;
    assign unf        = unf_q;

endmodule

// File: doc/updown_count_ctrl.md
# updown_count_ctrl

Controller for the host-triggered 32-bit up/down counter. It arbitrates between single-cycle host trigger pulses (reset, count-up, count-down) and a locally scheduled burst engine. The burst engine issues N steps of ±1 at a programmable period. It sits between the TriggerIn/WireIn endpoints and the WireOut endpoints that report count and status, entirely in the sys_clk domain.

## Interface
Parameters:
- WIDTH, 32, counter width
- LEN_W, 16, burst length width
- PER_W, 16, burst period width
- WRAP, 1, 1 = wrap on overflow/underflow; 0 = saturate

Ports:
- sys_clk  in  1  clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- trig_reset  in  1  host pulse; clears count
- trig_up  in  1  host pulse; count +1
- trig_down  in  1  host pulse; count −1
- burst_start  in  1  pulse; latch config and start a burst
- burst_abort  in  1  pulse; cancel a burst
- burst_len  in  LEN_W  number of steps
- burst_period  in  PER_W  idle cycles between steps (P)
- burst_dir  in  1  0 = up, 1 = down
- clear_flags  in  1  clears ovf/unf
- count  out  WIDTH  counter value (registered)
- steps_left  out  LEN_W  remaining burst steps
- busy  out  1  high in WAIT
- done  out  1  one-cycle pulse at burst completion
- ovf  out  1  sticky overflow
- unf  out  1  sticky underflow

## Operation
- Reset: count=0, steps_left=0, busy=0, done=0, ovf=0, unf=0, state=IDLE.
- States: IDLE, WAIT, DONE.
- IDLE:
  - burst_start with burst_len≠0: latch len/period/dir, timer=P, steps_left=len, go to WAIT.
  - burst_start with burst_len=0: go to DONE.
- WAIT:
  - If timer≠0: timer decrements.
  - If timer=0: a step is requested.
  - Granted step: count ±1, steps_left−1.
    - steps_left reaches 0: go to DONE.
    - Otherwise: timer=P, stay in WAIT.
  - Blocked step: stays requested (timer held at 0) and retries next cycle.
- DONE: done=1 for this cycle only; go to IDLE.
- burst_abort in WAIT or DONE: go to IDLE, no done pulse, count and steps_left retained. burst_abort in IDLE has no effect.
- burst_start while not IDLE is ignored. Latched config is unaffected by later input changes.
- Per-cycle count-update priority:
  1. trig_reset: count=0.
  2. Host up/down: trig_up and trig_down together give no change but still occupy the slot.
  3. Burst step.
- Any host trigger blocks that cycle's burst step. A burst continues across trig_reset.
- Overflow: +1 from all-ones sets ovf. Count becomes 0 if WRAP=1; holds at all-ones if WRAP=0.
- Underflow: −1 from 0 sets unf. Count becomes all-ones if WRAP=1; holds at 0 if WRAP=0.
- Flag set and clear_flags in the same cycle: set wins.

## Timing
- A host trigger sampled at edge t changes count at t+1.
- burst_start sampled at edge t:
  - busy=1 from t+1.
  - First step granted in cycle t+1+P; count visible at t+2+P.
  - Unblocked steps are spaced P+1 cycles apart. P=0 gives one step per cycle.
- Last step granted in cycle c: done=1 and busy=0 in cycle c+1; IDLE at c+2.
- A blocked step adds exactly one cycle per blocking host trigger.
- burst_len=0: done=1 in cycle t+1, and busy is never asserted.
- Throughput: one count update per cycle maximum.

## Structure
- Package ucc_pkg:
  - state enum {IDLE, WAIT, DONE}
  - direction constants DIR_UP/DIR_DOWN
- Sub-module step_timer holds the PER_W-bit down-counter.
  - Inputs: load, value, hold.
  - Output: zero.
- Saturate/wrap arithmetic lives in the top level as a single ±1 adder with carry detect.

## Test plan
- Reset, then 3× trig_up, then 1× trig_down: count=2, ovf=unf=0.
- burst_len=4, P=2, dir=up, start at cycle 0: count increments at cycles 4, 7, 10, 13; done at cycle 13; busy low from 13.
- Burst P=0, len=5, with trig_up in the cycle of the 2nd step: final count=6 and done one cycle later than unblocked.
- WRAP=1, count=0xFFFFFFFF, trig_up: count=0, ovf=1. clear_flags together with a new overflow leaves ovf=1.
- WRAP=0, count=0, trig_down: count=0, unf=1.
- Burst len=10, burst_abort after 3 steps: IDLE next cycle, no done, steps_left=7. burst_start while busy is ignored. burst_len=0 gives a done pulse at cycle 1.
